// File: rtl/chunked_add_sequencer.sv
// Multi-cycle wide adder: one CHUNK_WIDTH ripple stage reused over N_CHUNKS clocks.
// Optional subtract mode (op_sub port) enabled by macro CHUNKED_ADD_SEQUENCER_SUB_EN.
module chunked_add_sequencer #(
  parameter int unsigned DATA_WIDTH  = 24,
  parameter int unsigned CHUNK_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
`ifdef CHUNKED_ADD_SEQUENCER_SUB_EN
  input  logic                  op_sub,
`endif
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH:0]   result,
  output logic                  busy
);

  localparam int unsigned N_CHUNKS = DATA_WIDTH / CHUNK_WIDTH;
  localparam int unsigned IdxW     = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(N_CHUNKS - 1);

  if ((CHUNK_WIDTH == 0) || (DATA_WIDTH % CHUNK_WIDTH != 0)) begin : g_width_check
    $error("DATA_WIDTH must be a non-zero multiple of CHUNK_WIDTH");
  end

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                state_q, state_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic                  carry_q, carry_d;
  logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [DATA_WIDTH:0]   result_q, result_d;

  int unsigned            base;
  logic [CHUNK_WIDTH-1:0] a_chunk, b_chunk;
  logic [CHUNK_WIDTH:0]   sum;
  logic                   accept;
  logic                   sub_sel;

`ifdef CHUNKED_ADD_SEQUENCER_SUB_EN
  assign sub_sel = op_sub;
`else
  assign sub_sel = 1'b0;
`endif

  assign in_ready  = (state_q == StIdle) | ((state_q == StDone) & out_ready);
  assign accept    = in_valid & in_ready;
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign result    = result_q;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;

    base    = 32'(idx_q) * CHUNK_WIDTH;
    a_chunk = a_q[base +: CHUNK_WIDTH];
    b_chunk = b_q[base +: CHUNK_WIDTH];
    sum     = {1'b0, a_chunk} + {1'b0, b_chunk} + (CHUNK_WIDTH + 1)'(carry_q);

    unique case (state_q)
      StIdle: ;
      StRun: begin
        result_d[base +: CHUNK_WIDTH] = sum[CHUNK_WIDTH-1:0];
        carry_d = sum[CHUNK_WIDTH];
        idx_d   = idx_q + 1'b1;
        if (idx_q == LastIdx) begin
          result_d[DATA_WIDTH] = sum[CHUNK_WIDTH];
          idx_d   = '0;
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Accept overrides DONE->IDLE so a consumed result can be followed with no bubble.
    if (accept) begin
      a_d      = a;
      b_d      = sub_sel ? ~b : b;
      carry_d  = sub_sel;
      idx_d    = '0;
      result_d = '0;
      state_d  = StRun;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_chunked_add_sequencer.sv
// Scoreboard bench for chunked_add_sequencer: driver pushes model sums, monitor pops on handshake.
module tb_chunked_add_sequencer;
  localparam int W  = 24;
  localparam int CW = 6;
  localparam int N  = W / CW;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
`ifdef CHUNKED_ADD_SEQUENCER_SUB_EN
  logic         op_sub = 1'b0;
`endif
  logic         out_valid;
  logic         out_ready;
  logic [W:0]   result;
  logic         busy;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [W:0] exp_q[$];
  bit         rdy_rand = 1'b0;
  bit         rdy_val  = 1'b1;

  chunked_add_sequencer #(.DATA_WIDTH(W), .CHUNK_WIDTH(CW)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
`ifdef CHUNKED_ADD_SEQUENCER_SUB_EN
    .op_sub    (op_sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Reference: exact (W+1)-bit sum, or two's-complement difference with no-borrow MSB.
  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input bit sub);
    logic [W:0] r;
    if (sub) r = {1'b0, x} + {1'b0, ~y} + (W + 1)'(1);
    else     r = {1'b0, x} + {1'b0, y};
    return r;
  endfunction

  task automatic check(input string name, input logic [W:0] act, input logic [W:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Sole driver of out_ready; applied 2 time units after each rising edge.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_val;
    end
  end

  // Monitor: a handshake seen at the falling edge completes on the next rising edge.
  initial begin
    logic [W:0] e;
    forever begin
      @(negedge clk);
      if (resetn && out_valid && out_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_result: got %h expected none", result);
        end else begin
          e = exp_q.pop_front();
          if (result !== e) begin
            n_err++;
            $display("FAIL result: got %h expected %h at %0t", result, e, $time);
          end
        end
      end
    end
  end

  task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input bit sub);
    bit acc;
    acc = 1'b0;
    in_valid = 1'b1;
    a = ta;
    b = tb_v;
`ifdef CHUNKED_ADD_SEQUENCER_SUB_EN
    op_sub = sub;
`endif
    for (int n = 0; n < 200 && !acc; n++) begin
      @(negedge clk);
      if (in_ready) begin
        acc = 1'b1;
        exp_q.push_back(model(ta, tb_v, sub));
      end
      @(posedge clk);
    end
    #1;
    in_valid = 1'b0;
    check("accept", (W + 1)'(acc), (W + 1)'(1));
  endtask

  task automatic latency();
    check("in_ready_after_accept", (W + 1)'(in_ready), '0);
    for (int k = 1; k <= N; k++) begin
      @(posedge clk);
      #1;
      check("out_valid_latency", (W + 1)'(out_valid), (W + 1)'(k == N));
      if (k < N) check("busy_run", (W + 1)'(busy), (W + 1)'(1));
    end
  endtask

  task automatic wait_valid();
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 50 && !seen; n++) begin
      @(negedge clk);
      seen = out_valid;
    end
    check("wait_out_valid", (W + 1)'(seen), (W + 1)'(1));
  endtask

  task automatic settle();
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [W:0] bp_exp;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", (W + 1)'(out_valid), '0);
    check("rst_busy", (W + 1)'(busy), '0);
    check("rst_result", result, '0);
    resetn = 1'b1;
    #1;
    check("rst_in_ready", (W + 1)'(in_ready), (W + 1)'(1));

    // Basic add and latency
    issue(24'h000001, 24'h000002, 1'b0);
    latency();
    settle();
    // Full carry ripple
    issue(24'hFFFFFF, 24'h000001, 1'b0);
    latency();
    settle();

    // Backpressure: result held, no accept while pulsing in_valid
    rdy_val = 1'b0;
    bp_exp = model(24'h123456, 24'h654321, 1'b0);
    issue(24'h123456, 24'h654321, 1'b0);
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      a = W'($urandom);
      b = W'($urandom);
      @(negedge clk);
      check("bp_out_valid", (W + 1)'(out_valid), (W + 1)'(1));
      check("bp_in_ready", (W + 1)'(in_ready), '0);
      check("bp_result", result, bp_exp);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rdy_val = 1'b1;
    settle();

    // Back-to-back issue from DONE
    rdy_val = 1'b0;
    issue(24'h000001, 24'h000002, 1'b0);
    wait_valid();
    @(posedge clk);
    #1;
    rdy_val = 1'b1;
    issue(24'hFFFFFF, 24'hFFFFFF, 1'b0);
    check("b2b_out_valid_drop", (W + 1)'(out_valid), '0);
    latency();
    settle();

    // Reset mid-RUN
    issue(24'hABCDEF, 24'h111111, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b0;
    #1;
    exp_q.delete();
    check("abort_out_valid", (W + 1)'(out_valid), '0);
    check("abort_result", result, '0);
    check("abort_busy", (W + 1)'(busy), '0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    #1;
    check("post_abort_in_ready", (W + 1)'(in_ready), (W + 1)'(1));
    issue(24'h000010, 24'h000010, 1'b0);
    latency();
    settle();

`ifdef CHUNKED_ADD_SEQUENCER_SUB_EN
    issue(24'h000005, 24'h000007, 1'b1);
    latency();
    settle();
    issue(24'h000007, 24'h000005, 1'b1);
    latency();
    settle();
`endif

    // Randomized traffic with random consumer backpressure
    rdy_rand = 1'b1;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
`ifdef CHUNKED_ADD_SEQUENCER_SUB_EN
      issue(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
`else
      issue(W'($urandom), W'($urandom), 1'b0);
`endif
    end
    rdy_rand = 1'b0;
    rdy_val  = 1'b1;
    for (int n = 0; n < 100 && exp_q.size() != 0; n++) @(negedge clk);
    check("drain_empty", (W + 1)'(exp_q.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
